fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the pipelined processor. It holds the program counter, drives the word address into the combinational instruction memory, and captures the returned instruction into the IF/ID pipeline register for decode. Stall, flush and PC-redirect controls come from the hazard unit and from the branch/jump logic in decode.

## Interface
- `RESET_PC`, default 32'h0000_0000: word address loaded into the PC on reset.
- `IMEM_DEPTH`, default 32: number of instruction-memory words. A PC at or above this value is out of range.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `stall_f`  in  1: hold the PC.
- `stall_d`  in  1: hold the IF/ID register.
- `flush_d`  in  1: load a bubble into IF/ID.
- `pc_src`  in  2: next-PC select. 00 = sequential, 01 = branch, 10 = jump, 11 = reserved (treated as 00).
- `branch_target`  in  32: word address of the taken branch.
- `jump_target`  in  32: word address of the jump.
- `IMA`  out  32: instruction-memory word address; equals the PC register.
- `IMRD`  in  32: instruction word returned combinationally for `IMA`.
- `instr_d`  out  32: IF/ID instruction.
- `pcplus1_d`  out  32: IF/ID copy of PC+1 (word address).
- `valid_d`  out  1: IF/ID holds a real instruction.
- `fetch_fault`  out  1: sticky flag, set when an out-of-range PC is fetched.

## Operation
- The PC is a word address. The sequential successor is PC+1, computed modulo 2^32 (32'hFFFF_FFFF wraps to 0).
- Next-PC selection is a priority chain, highest first:
  1. `rst`: load `RESET_PC`.
  2. `stall_f`: hold the PC.
  3. `pc_src`=01: load `branch_target`.
  4. `pc_src`=10: load `jump_target`.
  5. Otherwise: load PC+1.
- Because `stall_f` outranks a redirect, a redirect presented while `stall_f`=1 is dropped. The hazard unit keeps `pc_src` valid until the stall releases.
- IF/ID update is also a priority chain, highest first:
  1. `rst`: clear.
  2. `flush_d`: load a bubble (`instr_d`=NOP, `pcplus1_d`=0, `valid_d`=0).
  3. `stall_d`: hold.
  4. Otherwise: load `instr_d`=IMRD, `pcplus1_d`=PC+1, `valid_d`=1.
- A flush wins over `stall_d` when both are asserted.
- Out-of-range fetch (PC ≥ `IMEM_DEPTH`) in a cycle where IF/ID would load normally:
  - `instr_d`=NOP, `valid_d`=0, `pcplus1_d`=PC+1.
  - `fetch_fault` is set and stays set until `rst`.
  - The PC still advances per `pc_src`, so a jump back into range recovers execution.
- NOP = 32'h0000_0000.

## Timing
- Reset values: PC=`RESET_PC`, `IMA`=`RESET_PC`, `instr_d`=0, `pcplus1_d`=0, `valid_d`=0, `fetch_fault`=0.
- `IMA` is registered. `IMRD` is sampled in the same cycle.
- Fetch-to-decode latency is one cycle. The instruction at `RESET_PC` appears on `instr_d` on the first edge after `rst` deasserts.
- A redirect sampled at edge N puts the target on `IMA` after edge N. The target instruction reaches `instr_d` at edge N+1.
- The wrong-path instruction fetched in cycle N is removed by `flush_d` at edge N. Decode asserts `flush_d` together with the redirect.
- Asserting `rst` mid-stream overrides every other input at that edge.

## Structure
- Shared package holds:
  - `PC_SRC_SEQ`=2'b00, `PC_SRC_BR`=2'b01, `PC_SRC_J`=2'b10.
  - `NOP_INSTR`=32'h0000_0000.
  - Pipeline-register width constants.
- One sub-module, `if_id_reg`, implements the IF/ID register with its reset, flush and stall priority.
- PC register, next-PC mux and range check live in `fetch_stage`.

## Test plan
- Reset and sequential fetch: memory loaded with 20100000, 20110005, 20120001; release `rst` -> `instr_d` = 20100000, 20110005, 20120001 on successive edges, `pcplus1_d` = 1, 2, 3, `valid_d`=1.
- Stall: hold `stall_f`=`stall_d`=1 for 2 cycles at PC=4 -> `IMA` stays 4 and `instr_d` is unchanged; after release, PC=5 follows.
- Branch with flush: at PC=4 assert `pc_src`=01, `branch_target`=11, `flush_d`=1 -> next `IMA`=11, `instr_d`=0, `valid_d`=0; next edge `instr_d`=IMEM[11].
- Jump and priority: `pc_src`=10, `jump_target`=4 together with `stall_f`=1 -> PC held. Drop `stall_f` -> `IMA`=4.
  - Same cycle, `flush_d`=`stall_d`=1 -> bubble is loaded.
- Out-of-range fetch: `jump_target`=40 -> `fetch_fault`=1, `valid_d`=0, `instr_d`=0. Then jump to 0 -> valid fetch resumes, `fetch_fault` stays 1 until `rst`.
- Wrap-around and mid-run reset: with `RESET_PC`=32'hFFFF_FFFF, next `IMA`=0. Asserting `rst` mid-stall restores every reset value on the next edge.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_stage_pkg;

   localparam int ADDR_W  = 32;
   localparam int INSTR_W = 32;

   // Next-PC select encodings; 2'b11 is reserved and behaves as sequential.
   localparam logic [1:0] PC_SRC_SEQ = 2'b00;
   localparam logic [1:0] PC_SRC_BR  = 2'b01;
   localparam logic [1:0] PC_SRC_J   = 2'b10;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

   // Contents of the IF/ID pipeline register.
   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pcplus1;
      logic               valid;
   } if_id_t;

   localparam int IF_ID_W = $bits(if_id_t);

   localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pcplus1: '0, valid: 1'b0};

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: reset, then flush, then stall, then load.
module if_id_reg
   import fetch_stage_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   flush,
   input  logic   stall,
   input  if_id_t d,
   output if_id_t q
);

   // Priority chain: a flush beats a stall so a squashed slot never lingers.
   always_ff @(posedge clk) begin
      // NOTE: state is written with <= so every register samples pre-edge values.
      if (rst)
         q <= IF_ID_BUBBLE;
      else if (flush)
         q <= IF_ID_BUBBLE;
      else if (!stall)
         q <= d;
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC select, range check, IF/ID.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
   parameter int                IMEM_DEPTH = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall_f,
   input  logic                stall_d,
   input  logic                flush_d,
   input  logic [1:0]          pc_src,
   input  logic [ADDR_W-1:0]   branch_target,
   input  logic [ADDR_W-1:0]   jump_target,
   output logic [ADDR_W-1:0]   IMA,
   input  logic [INSTR_W-1:0]  IMRD,
   output logic [INSTR_W-1:0]  instr_d,
   output logic [ADDR_W-1:0]   pcplus1_d,
   output logic                valid_d,
   output logic                fetch_fault
);

   localparam logic [ADDR_W-1:0] IMEM_LIMIT = ADDR_W'(IMEM_DEPTH);

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_next;
   logic [ADDR_W-1:0] pc_plus1;
   logic              in_range;
   logic              if_id_load;
   if_id_t            if_id_d;
   if_id_t            if_id_q;

   // Sequential successor wraps naturally at 32 bits.
   assign pc_plus1 = pc_q + 32'd1;
   assign in_range = (pc_q < IMEM_LIMIT);
   assign IMA      = pc_q;

   // Next-PC select: a stall drops any redirect presented in the same cycle.
   always_comb begin
      // NOTE: default first so no path through the block leaves pc_next unassigned (no latch).
      pc_next = pc_plus1;
      if (stall_f)
         pc_next = pc_q;
      else if (pc_src == PC_SRC_BR)
         pc_next = branch_target;
      else if (pc_src == PC_SRC_J)
         pc_next = jump_target;
   end

   // PC register.
   always_ff @(posedge clk) begin
      if (rst)
         pc_q <= RESET_PC;
      else
         pc_q <= pc_next;
   end

   // Out-of-range fetches enter decode as an invalid NOP but keep PC+1.
   always_comb begin
      if_id_d.instr   = in_range ? IMRD : NOP_INSTR;
      if_id_d.pcplus1 = pc_plus1;
      if_id_d.valid   = in_range;
   end

   assign if_id_load = !flush_d && !stall_d;

   // Sticky fault flag, raised only when the bad fetch actually enters IF/ID.
   always_ff @(posedge clk) begin
      if (rst)
         fetch_fault <= 1'b0;
      else if (if_id_load && !in_range)
         fetch_fault <= 1'b1;
   end

   if_id_reg u_if_id_reg (
      .clk   (clk),
      .rst   (rst),
      .flush (flush_d),
      .stall (stall_d),
      .d     (if_id_d),
      .q     (if_id_q)
   );

   assign instr_d   = if_id_q.instr;
   assign pcplus1_d = if_id_q.pcplus1;
   assign valid_d   = if_id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_f;
   logic        stall_d;
   logic        flush_d;
   logic [1:0]  pc_src;
   logic [31:0] branch_target;
   logic [31:0] jump_target;
   logic [31:0] ima;
   logic [31:0] imrd;
   logic [31:0] instr_d;
   logic [31:0] pcplus1_d;
   logic        valid_d;
   logic        fetch_fault;

   logic [31:0] w_ima;
   logic [31:0] w_imrd;
   logic [31:0] w_instr_d;
   logic [31:0] w_pcplus1_d;
   logic        w_valid_d;
   logic        w_fetch_fault;

   logic [31:0] imem [0:31];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Combinational instruction memory; out-of-range reads return junk.
   assign imrd   = (ima   < 32) ? imem[ima[4:0]]   : 32'hDEAD_BEEF;
   assign w_imrd = (w_ima < 32) ? imem[w_ima[4:0]] : 32'hDEAD_BEEF;

   fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_DEPTH(32)) dut (
      .clk(clk), .rst(rst), .stall_f(stall_f), .stall_d(stall_d),
      .flush_d(flush_d), .pc_src(pc_src), .branch_target(branch_target),
      .jump_target(jump_target), .IMA(ima), .IMRD(imrd), .instr_d(instr_d),
      .pcplus1_d(pcplus1_d), .valid_d(valid_d), .fetch_fault(fetch_fault)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFF), .IMEM_DEPTH(32)) dut_wrap (
      .clk(clk), .rst(rst), .stall_f(stall_f), .stall_d(stall_d),
      .flush_d(flush_d), .pc_src(pc_src), .branch_target(branch_target),
      .jump_target(jump_target), .IMA(w_ima), .IMRD(w_imrd), .instr_d(w_instr_d),
      .pcplus1_d(w_pcplus1_d), .valid_d(w_valid_d), .fetch_fault(w_fetch_fault)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Advance one rising edge and settle before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0; pc_src = PC_SRC_SEQ;
   endtask

   task automatic expect_id(input string tag, input logic [31:0] e_ima,
                            input logic [31:0] e_instr, input logic [31:0] e_pcp1,
                            input logic e_valid);
      check({tag, ".ima"},     ima,       e_ima);
      check({tag, ".instr"},   instr_d,   e_instr);
      check({tag, ".pcplus1"}, pcplus1_d, e_pcp1);
      check({tag, ".valid"},   32'(valid_d), 32'(e_valid));
   endtask

   initial begin
      for (int i = 0; i < 32; i++) imem[i] = 32'h1000_0000 + 32'(i);
      imem[0] = 32'h2010_0000;
      imem[1] = 32'h2011_0005;
      imem[2] = 32'h2012_0001;

      branch_target = 32'd0;
      jump_target   = 32'd0;
      idle();
      rst = 1'b1;

      // Reset state.
      step();
      expect_id("reset", 32'd0, 32'd0, 32'd0, 1'b0);
      check("reset.fault", 32'(fetch_fault), 32'd0);
      check("wrap.reset_ima", w_ima, 32'hFFFF_FFFF);

      // Sequential fetch.
      rst = 1'b0;
      step();
      expect_id("seq0", 32'd1, 32'h2010_0000, 32'd1, 1'b1);
      check("wrap.ima", w_ima, 32'd0);
      check("wrap.pcplus1", w_pcplus1_d, 32'd0);
      check("wrap.valid", 32'(w_valid_d), 32'd0);
      check("wrap.fault", 32'(w_fetch_fault), 32'd1);
      step();
      expect_id("seq1", 32'd2, 32'h2011_0005, 32'd2, 1'b1);
      step();
      expect_id("seq2", 32'd3, 32'h2012_0001, 32'd3, 1'b1);
      step();
      expect_id("seq3", 32'd4, 32'h1000_0003, 32'd4, 1'b1);

      // Two-cycle stall at PC=4.
      stall_f = 1'b1; stall_d = 1'b1;
      step();
      expect_id("stall1", 32'd4, 32'h1000_0003, 32'd4, 1'b1);
      step();
      expect_id("stall2", 32'd4, 32'h1000_0003, 32'd4, 1'b1);
      idle();
      step();
      expect_id("unstall", 32'd5, 32'h1000_0004, 32'd5, 1'b1);

      // Return to PC=4 with a flushed jump.
      pc_src = PC_SRC_J; jump_target = 32'd4; flush_d = 1'b1;
      step();
      expect_id("j4", 32'd4, 32'd0, 32'd0, 1'b0);

      // Branch with flush at PC=4.
      pc_src = PC_SRC_BR; branch_target = 32'd11; flush_d = 1'b1;
      step();
      expect_id("br_flush", 32'd11, 32'd0, 32'd0, 1'b0);
      idle();
      step();
      expect_id("br_target", 32'd12, 32'h1000_000B, 32'd12, 1'b1);

      // Jump presented under stall_f is dropped.
      pc_src = PC_SRC_J; jump_target = 32'd4; stall_f = 1'b1;
      step();
      expect_id("j_stalled", 32'd12, 32'h1000_000C, 32'd13, 1'b1);
      // Jump taken; flush beats stall_d in the same cycle.
      stall_f = 1'b0; flush_d = 1'b1; stall_d = 1'b1;
      step();
      expect_id("j_flush_prio", 32'd4, 32'd0, 32'd0, 1'b0);
      idle();
      step();
      expect_id("j_target", 32'd5, 32'h1000_0004, 32'd5, 1'b1);

      // Out-of-range fetch.
      pc_src = PC_SRC_J; jump_target = 32'd40; flush_d = 1'b1;
      step();
      expect_id("oor_jump", 32'd40, 32'd0, 32'd0, 1'b0);
      check("oor_jump.fault", 32'(fetch_fault), 32'd0);
      idle();
      step();
      expect_id("oor_fetch", 32'd41, 32'd0, 32'd41, 1'b0);
      check("oor_fetch.fault", 32'(fetch_fault), 32'd1);
      pc_src = PC_SRC_J; jump_target = 32'd0; flush_d = 1'b1;
      step();
      expect_id("recover_jump", 32'd0, 32'd0, 32'd0, 1'b0);
      idle();
      step();
      expect_id("recover", 32'd1, 32'h2010_0000, 32'd1, 1'b1);
      check("recover.fault", 32'(fetch_fault), 32'd1);

      // Reserved pc_src acts as sequential.
      pc_src = 2'b11; branch_target = 32'd20; jump_target = 32'd21;
      step();
      expect_id("rsvd", 32'd2, 32'h2011_0005, 32'd2, 1'b1);

      // Reset asserted mid-stall.
      idle();
      stall_f = 1'b1; stall_d = 1'b1;
      step();
      check("pre_rst.ima", ima, 32'd2);
      rst = 1'b1;
      step();
      expect_id("mid_rst", 32'd0, 32'd0, 32'd0, 1'b0);
      check("mid_rst.fault", 32'(fetch_fault), 32'd0);
      check("mid_rst.wrap_ima", w_ima, 32'hFFFF_FFFF);
      check("mid_rst.wrap_fault", 32'(w_fetch_fault), 32'd0);

      rst = 1'b0;
      idle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Safety bound so the run always terminates.
   initial begin
      #100000;
      errors++;
      $display("FAIL timeout: got no finish expected finish");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
